ins_fetch: RTL and testbench

Instruction fetch unit that supplies the instruction register. It owns the fetch program counter, reads the instruction memory over a req/ack handshake and holds prefetched instructions in a small FIFO. It presents the oldest instruction on `INS_BUS`, which feeds the IR input bus. It sits between the instruction memory and the IR, and takes jump and halt commands from the control unit.

---
 rtl/ins_fetch.sv | 152 +++++++++++++++
 tb/tb_ins_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch.sv
// Instruction fetch unit: owns the fetch PC, drives the instruction memory
// req/ack handshake and holds prefetched {addr, instr} pairs for the IR.
module ins_fetch #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] INS_BUS,
    output logic [AW-1:0] ins_addr,
    output logic          ins_valid,
    input  logic          ir_load,
    input  logic          jump,
    input  logic [AW-1:0] jump_addr,
    input  logic          halt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic          r_mem_req;
    logic [AW-1:0] r_mem_addr;

    logic [AW-1:0] r_fa [DEPTH];
    logic [DW-1:0] r_fd [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;

    logic w_ack;
    logic w_push;
    logic w_pop;
    logic w_can_req;
    logic w_load_addr;

    assign ins_valid = (r_count != '0);
    assign INS_BUS   = ins_valid ? r_fd[r_rd] : '0;
    assign ins_addr  = ins_valid ? r_fa[r_rd] : '0;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;

    // An ack only counts while a request is on the bus; a jump discards it.
    assign w_ack  = mem_ack && (r_state != S_IDLE);
    assign w_push = w_ack && (r_state == S_REQ) && !jump;
    assign w_pop  = ir_load && ins_valid && !jump;

    always_comb begin
        w_count_nxt = r_count;
        if (jump) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_comb begin
        w_pc_nxt = r_pc;
        if (jump) begin
            w_pc_nxt = jump_addr;
        end else if (w_push) begin
            w_pc_nxt = r_pc + AW'(1);
        end
    end

    assign w_can_req = !halt && (w_count_nxt < CW'(DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_can_req) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_ack) begin
                    w_state_nxt = w_can_req ? S_REQ : S_IDLE;
                end else if (jump) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (w_ack) begin
                    w_state_nxt = w_can_req ? S_REQ : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A new address is launched only when a fresh handshake starts.
    assign w_load_addr = ((r_state == S_IDLE) || w_ack)
                       && (w_state_nxt == S_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_mem_req <= (w_state_nxt != S_IDLE);
            if (w_load_addr) begin
                r_mem_addr <= w_pc_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fa[i] <= '0;
                r_fd[i] <= '0;
            end
        end else begin
            r_count <= w_count_nxt;
            if (jump) begin
                r_rd <= '0;
                r_wr <= '0;
            end else begin
                if (w_push) begin
                    r_fa[r_wr] <= r_pc;
                    r_fd[r_wr] <= mem_data;
                    r_wr       <= r_wr + PW'(1);
                end
                if (w_pop) begin
                    r_rd <= r_rd + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ins_fetch.sv
// Randomised scoreboard bench for ins_fetch: a queue-based model of the
// program-order instruction stream is compared against the IR-side outputs.
module tb_ins_fetch;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 2;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } ent_t;

    logic          clk;
    logic          rst_n;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] INS_BUS;
    logic [AW-1:0] ins_addr;
    logic          ins_valid;
    logic          ir_load;
    logic          jump;
    logic [AW-1:0] jump_addr;
    logic          halt;

    ins_fetch #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .INS_BUS   (INS_BUS),
        .ins_addr  (ins_addr),
        .ins_valid (ins_valid),
        .ir_load   (ir_load),
        .jump      (jump),
        .jump_addr (jump_addr),
        .halt      (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;

    // Reference model: expected FIFO contents, next fetch address, and
    // whether the request on the bus predates the latest jump.
    ent_t       q[$];
    logic [7:0] m_pc;
    logic [7:0] m_old;
    bit         m_req;
    bit         m_stale;
    bit         tb_active;

    int lat;
    int wcnt;
    bit rand_lat;
    bit rand_ack;

    function automatic logic [7:0] memf(logic [7:0] a);
        return a + 8'h10;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc    = 8'h00;
        m_old   = 8'h00;
        m_req   = 1'b0;
        m_stale = 1'b0;
    endtask

    // Apply the effect of the edge that just passed (inputs still held).
    task automatic model_update();
        bit acc;
        if (!tb_active) return;
        acc = m_req && mem_ack && !jump && !m_stale;
        if (m_req && mem_ack) m_stale = 1'b0;
        if (jump) begin
            q.delete();
            if (m_req && !mem_ack && !m_stale) begin
                m_old   = m_pc;
                m_stale = 1'b1;
            end
            m_pc = jump_addr;
        end else if (acc) begin
            q.push_back('{a: m_pc, d: memf(m_pc)});
            m_pc = m_pc + 8'd1;
        end
        m_req = (m_req && !mem_ack) || (!halt && q.size() < DEPTH);
    endtask

    task automatic mem_drive();
        if (mem_ack) begin
            wcnt = 0;
            if (rand_lat) lat = $urandom_range(0, 3);
        end
        if (mem_req) begin
            if (wcnt >= lat) begin
                mem_ack  = 1'b1;
                mem_data = memf(mem_addr);
            end else begin
                mem_ack  = 1'b0;
                mem_data = 8'($urandom);
                wcnt++;
            end
        end else begin
            wcnt     = 0;
            mem_ack  = rand_ack && ($urandom_range(0, 7) == 0);
            mem_data = 8'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_update();
        mem_drive();
        jump = 1'b0;
    endtask

    // Monitor: compares outputs to the model and pops on consumption.
    always @(negedge clk) begin
        if (tb_active) begin
            chk("ins_valid", ins_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("head_bus", INS_BUS, q[0].d);
                chk("head_addr", ins_addr, q[0].a);
            end else begin
                chk("empty_bus", INS_BUS, 0);
                chk("empty_addr", ins_addr, 0);
            end
            chk("mem_req", mem_req, m_req);
            if (m_req) begin
                chk("mem_addr", mem_addr, m_stale ? m_old : m_pc);
            end
            if (ir_load && !jump && q.size() != 0) begin
                ent_t e;
                e = q.pop_front();
                chk("pop_bus", INS_BUS, e.d);
                chk("pop_addr", ins_addr, e.a);
                n_pops++;
            end
        end
    end

    task automatic async_reset();
        #2;
        rst_n     = 1'b0;
        tb_active = 1'b0;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_valid", ins_valid, 0);
        chk("arst_bus", INS_BUS, 0);
        chk("arst_addr", ins_addr, 0);
        @(posedge clk);
        #1;
        chk("arst_hold_req", mem_req, 0);
        #2;
        mem_ack   = 1'b0;
        ir_load   = 1'b0;
        jump      = 1'b0;
        halt      = 1'b0;
        wcnt      = 0;
        model_reset();
        rst_n     = 1'b1;
        tb_active = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bit         found;
        int         p0;
        logic [7:0] a;

        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_data  = '0;
        ir_load   = 1'b0;
        jump      = 1'b0;
        jump_addr = '0;
        halt      = 1'b0;
        lat       = 0;
        wcnt      = 0;
        rand_lat  = 1'b0;
        rand_ack  = 1'b0;
        tb_active = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", ins_valid, 0);
        chk("rst_bus", INS_BUS, 0);
        #3;
        rst_n     = 1'b1;
        tb_active = 1'b1;

        // Startup fill with IR idle.
        repeat (8) tick();
        chk("start_bus", INS_BUS, 8'h10);
        chk("start_addr", ins_addr, 8'h00);
        chk("start_req", mem_req, 0);

        // Zero-wait streaming through the 0xFF -> 0x00 wrap.
        ir_load = 1'b1;
        p0 = n_pops;
        repeat (300) tick();
        chk("stream_rate", (n_pops - p0) >= 298, 1);

        // Jump while address 5 is pending on a slow memory.
        lat = 3;
        jump = 1'b1;
        jump_addr = 8'h03;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            found = mem_req && (mem_addr == 8'h05) && !mem_ack;
        end
        chk("wait_addr5", found, 1);
        jump = 1'b1;
        jump_addr = 8'h40;
        ir_load = 1'b0;
        repeat (3) begin
            tick();
            chk("drop_req", mem_req, 1);
            chk("drop_addr", mem_addr, 8'h05);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = ins_valid;
        end
        chk("wait_jump_data", found, 1);
        chk("jump_bus", INS_BUS, 8'h50);
        chk("jump_addr", ins_addr, 8'h40);

        // Jump, pop and ack all in one cycle.
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = mem_ack && ins_valid;
        end
        chk("wait_simul", found, 1);
        jump = 1'b1;
        jump_addr = 8'h80;
        ir_load = 1'b1;
        tick();
        chk("simul_flush", ins_valid, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = ins_valid;
        end
        chk("wait_simul_data", found, 1);
        chk("simul_addr", ins_addr, 8'h80);
        chk("simul_bus", INS_BUS, 8'h90);

        // Halt with a fetch in flight.
        lat = 2;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = mem_req && !mem_ack;
        end
        chk("wait_halt", found, 1);
        a = mem_addr;
        halt = 1'b1;
        ir_load = 1'b0;
        repeat (8) tick();
        chk("halt_req", mem_req, 0);
        chk("halt_pushed", ins_valid, 1);
        halt = 1'b0;
        ir_load = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = mem_req;
        end
        chk("wait_resume", found, 1);
        chk("resume_addr", mem_addr, a + 8'd1);

        // Asynchronous reset in the middle of a handshake.
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = mem_req && !mem_ack;
        end
        chk("wait_arst", found, 1);
        async_reset();
        lat = 0;
        tick();
        chk("restart_req", mem_req, 1);
        chk("restart_addr", mem_addr, 0);

        // Random traffic.
        rand_lat = 1'b1;
        rand_ack = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            tick();
            ir_load = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 15) == 0) begin
                jump      = 1'b1;
                jump_addr = 8'($urandom);
            end
            if ($urandom_range(0, 19) == 0) halt = ~halt;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
